// File: rtl/image_gauss3x3.sv
// image_gauss3x3: streaming 3x3 Gaussian blur with zero padding.
// Two line buffers feed a 3x3 window; outputs trail input by one line plus one pixel.
module image_gauss3x3 #(
  parameter int WIDTH = 410,
  parameter int DEPTH = 361
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  output logic       in_ready,
  output logic [7:0] pixel_out,
  output logic       out_valid,
  output logic       finish
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = $clog2(DEPTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t        state;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [1:0]    dcnt;
  logic [7:0]    win [3][3];
  logic          v1;
  logic          ml, mr, mt, mb;

  logic [7:0]    lb_a [WIDTH];
  logic [7:0]    lb_b [WIDTH];

  logic          consume;
  logic [7:0]    p;
  logic          wrap;
  logic          last_in;
  logic          last_inj;
  logic          cvalid;
  logic          ml_n, mr_n, mt_n, mb_n;
  logic [7:0]    g [3][3];
  logic [11:0]   sum;

  always_comb begin
    consume  = (state == RUN && pixel_valid) ||
               (state == FLUSH && dcnt == 2'd0);
    p        = (state == RUN) ? pixel_in : 8'd0;
    wrap     = (cx == '0);
    last_in  = (cx == XW'(WIDTH - 1)) && (cy == YW'(DEPTH - 1));
    last_inj = wrap && (cy == YW'(DEPTH + 1));
    cvalid   = (cy >= YW'(2)) || (cy == YW'(1) && !wrap);
    // Center sits one line and one pixel behind the incoming sample
    ml_n     = (cx == XW'(1));
    mr_n     = wrap;
    mt_n     = wrap ? (cy == YW'(2)) : (cy == YW'(1));
    mb_n     = wrap ? (cy == YW'(DEPTH + 1)) : (cy == YW'(DEPTH));
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        g[r][c] = win[r][c];
        if ((r == 0 && mt) || (r == 2 && mb) ||
            (c == 0 && ml) || (c == 2 && mr))
          g[r][c] = 8'd0;
      end
    end
    sum = 12'(g[0][0]) + (12'(g[0][1]) << 1) + 12'(g[0][2])
        + (12'(g[1][0]) << 1) + (12'(g[1][1]) << 2)
        + (12'(g[1][2]) << 1)
        + 12'(g[2][0]) + (12'(g[2][1]) << 1) + 12'(g[2][2]);
  end

  always_ff @(posedge clk) begin
    if (consume) begin
      lb_b[cx] <= lb_a[cx];
      lb_a[cx] <= p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      finish    <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      dcnt      <= 2'd0;
      v1        <= 1'b0;
      ml        <= 1'b0;
      mr        <= 1'b0;
      mt        <= 1'b0;
      mb        <= 1'b0;
      out_valid <= 1'b0;
      pixel_out <= 8'd0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= 8'd0;
    end else begin
      v1        <= consume && cvalid;
      out_valid <= v1;
      if (v1)
        pixel_out <= 8'(sum >> 4);
      if (consume) begin
        ml <= ml_n;
        mr <= mr_n;
        mt <= mt_n;
        mb <= mb_n;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_b[cx];
        win[1][2] <= lb_a[cx];
        win[2][2] <= p;
        if (cx == XW'(WIDTH - 1)) begin
          cx <= '0;
          cy <= cy + YW'(1);
        end else begin
          cx <= cx + XW'(1);
        end
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            in_ready <= 1'b1;
            finish   <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            dcnt     <= 2'd0;
            for (int r = 0; r < 3; r++)
              for (int c = 0; c < 3; c++)
                win[r][c] <= 8'd0;
          end
        end
        RUN: begin
          if (pixel_valid && last_in) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          // Drain two cycles so the last output precedes finish
          if (dcnt == 2'd0) begin
            if (last_inj)
              dcnt <= 2'd1;
          end else if (dcnt == 2'd2) begin
            state  <= DONE;
            finish <= 1'b1;
            dcnt   <= 2'd0;
          end else begin
            dcnt <= dcnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_gauss3x3.sv
// Scoreboard bench for image_gauss3x3 on an 8x6 frame.
// Driver queues expected pixels; a negedge monitor checks values and latency.
module tb_image_gauss3x3;

  localparam int W = 8;
  localparam int D = 6;
  localparam int N = W * D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       in_ready;
  logic [7:0] pixel_out;
  logic       out_valid;
  logic       finish;

  always #5 clk = ~clk;

  image_gauss3x3 #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .in_ready   (in_ready),
    .pixel_out  (pixel_out),
    .out_valid  (out_valid),
    .finish     (finish)
  );

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         img [N];
  logic [7:0] exp_q [$];
  int         due_q [$];
  int         acc_cnt = 0;
  int         inj_left = 0;
  int         out_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Stream-index tracker and output checker
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      due_q.delete();
      acc_cnt  = 0;
      inj_left = 0;
    end else begin
      if (pixel_valid && in_ready) begin
        if (acc_cnt >= W + 1) due_q.push_back(cyc + 2);
        acc_cnt++;
        if (acc_cnt == N) inj_left = W + 1;
      end else if (inj_left > 0) begin
        if (acc_cnt >= W + 1) due_q.push_back(cyc + 2);
        acc_cnt++;
        inj_left--;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          check($sformatf("pix%0d", out_cnt), 32'(pixel_out),
                32'(exp_q.pop_front()));
          if (due_q.size() > 0)
            check($sformatf("latency%0d", out_cnt), cyc, due_q.pop_front());
          else
            check("latency_no_input", 32'd1, 32'd0);
        end
        out_cnt++;
      end
    end
  end

  function automatic int model(input int x, input int y);
    int s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < D)
          s += img[(y + dy) * W + x + dx] *
               ((dx == 0) ? 2 : 1) * ((dy == 0) ? 2 : 1);
    return s >> 4;
  endfunction

  // mode 0: constant 16, mode 1: 255 impulse at (4,3), mode 2: ramp
  task automatic load_frame(input int mode);
    for (int y = 0; y < D; y++)
      for (int x = 0; x < W; x++)
        case (mode)
          0:       img[y * W + x] = 16;
          1:       img[y * W + x] = (x == 4 && y == 3) ? 255 : 0;
          default: img[y * W + x] = x * 10 + y;
        endcase
    for (int y = 0; y < D; y++)
      for (int x = 0; x < W; x++) begin
        int ex, ey, e;
        ex = (x == 0 || x == W - 1) ? 1 : 0;
        ey = (y == 0 || y == D - 1) ? 1 : 0;
        if (mode == 0) begin
          e = (ex + ey == 2) ? 9 : (ex + ey == 1) ? 12 : 16;
        end else if (mode == 1) begin
          ex = (x > 4) ? x - 4 : 4 - x;
          ey = (y > 3) ? y - 3 : 3 - y;
          if (ex > 1 || ey > 1)     e = 0;
          else if (ex + ey == 0)    e = 63;
          else if (ex + ey == 1)    e = 31;
          else                      e = 15;
        end else begin
          e = model(x, y);
        end
        exp_q.push_back(8'(e));
      end
  endtask

  task automatic run_frame(input int mode, input bit gaps,
                           input int abort_at, input bit poke);
    bit acc;
    int guard;
    load_frame(mode);
    out_cnt  = 0;
    acc_cnt  = 0;
    inj_left = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("finish_clr_on_start", 32'(finish), 32'd0);
    check("in_ready_run", 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (i == abort_at) begin
        pixel_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_pixel_out", 32'(pixel_out), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_in_ready", 32'(in_ready), 32'd0);
        return;
      end
      if (gaps) begin
        pixel_valid = 1'b0;
        @(posedge clk); #1;
      end
      pixel_valid = 1'b1;
      pixel_in    = 8'(img[i]);
      if (poke && i == 10) start = 1'b1;
      guard = 0;
      do begin
        @(negedge clk) acc = in_ready;
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
    end
    pixel_valid = 1'b0;
    guard = 0;
    while (!finish && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("finish_high", 32'(finish), 32'd1);
    check("out_count", out_cnt, N);
    check("queue_empty", exp_q.size(), 0);
    check("done_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b1;
    start       = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pixel_out", 32'(pixel_out), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pixel_valid = 1'b1;
    pixel_in    = 8'd99;
    repeat (3) @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    pixel_valid = 1'b0;

    run_frame(0, 1'b0, -1, 1'b0);
    run_frame(0, 1'b1, -1, 1'b0);
    run_frame(2, 1'b0, 20, 1'b0);
    run_frame(2, 1'b0, -1, 1'b1);

    pixel_valid = 1'b1;
    pixel_in    = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check("done_drop_in_ready", 32'(in_ready), 32'd0);
    check("done_finish_held", 32'(finish), 32'd1);
    pixel_valid = 1'b0;
    run_frame(1, 1'b0, -1, 1'b0);

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
